// File: rtl/daq_pkg.sv
// Shared DAQ types: packet type codes, watchdog marker and collector FSM states.
package daq_pkg;

  localparam logic [7:0]  DAQT_DRO_DATA = 8'd48;
  localparam logic [15:0] DAQ_WD_MARKER = 16'hDEAD;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBusy  = 2'd1,
    StDrain = 2'd2
  } daq_state_e;

endpackage

// File: rtl/daq_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count; DEPTH must be a power of 2.
module daq_sync_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 512
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           push_i,
  input  logic [WIDTH-1:0]               wdata_i,
  input  logic                           pop_i,
  output logic [WIDTH-1:0]               rdata_o,
  output logic                           empty_o,
  output logic                           full_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o
);

  localparam int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CountW = $clog2(DEPTH+1);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CountW-1:0] count_q;
  logic              do_push, do_pop;

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (!do_push && do_pop) count_q <= count_q - 1'b1;
    end
  end

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CountW'(DEPTH));
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/daq_collector.sv
// Round-robin DAQ collector: grants one producer at a time into a word FIFO drained to the uplink.
// Optional idle watchdog enabled by defining DAQ_WATCHDOG_EN.
module daq_collector
  import daq_pkg::*;
#(
  parameter int unsigned NREQ      = 2,
  parameter int unsigned DEPTH     = 512,
  parameter int unsigned MAX_PKT   = 3,
  parameter int unsigned WD_CYCLES = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NREQ-1:0]            daq_req_i,
  output logic [NREQ-1:0]            daq_grant_o,
  input  logic [32*NREQ-1:0]         daq_data_i,
  input  logic [NREQ-1:0]            daq_valid_i,
  input  logic [NREQ-1:0]            daq_end_i,
  output logic [31:0]                out_data_o,
  output logic                       out_end_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [$clog2(DEPTH+1)-1:0] fill_o,
  output logic                       err_o,
  input  logic                       err_clear_i
);

  localparam int unsigned SelW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned FillW = $clog2(DEPTH+1);
  localparam int unsigned CntW  = $clog2(MAX_PKT+1);
`ifdef DAQ_WATCHDOG_EN
  localparam int unsigned Resv  = MAX_PKT + 1;  // room for the timeout marker
`else
  localparam int unsigned Resv  = MAX_PKT;
`endif

  daq_state_e      state_q;
  logic [SelW-1:0] sel_q, rr_q, pick_idx;
  logic [CntW-1:0] cnt_q;
  logic [NREQ-1:0] grant_q, sel_mask;
  logic            err_q, pick_found, space_ok, stray, overrun, wd_fire;
  logic            sel_valid, sel_end, push, push_end, fifo_empty, fifo_full;
  logic [31:0]     sel_data, push_data;
  logic [FillW-1:0] fill;
  logic [32:0]     fifo_rdata;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (!pick_found && daq_req_i[(int'(rr_q) + i) % int'(NREQ)]) begin
        pick_found = 1'b1;
        pick_idx   = SelW'((int'(rr_q) + i) % int'(NREQ));
      end
    end
  end

  assign space_ok  = !fifo_full && ((FillW'(DEPTH) - fill) >= FillW'(Resv));
  assign sel_valid = daq_valid_i[sel_q];
  assign sel_end   = daq_end_i[sel_q];
  assign sel_data  = daq_data_i[32*int'(sel_q) +: 32];

  always_comb begin
    sel_mask = NREQ'(1) << sel_q;
    stray    = (state_q == StIdle) ? |daq_valid_i : |(daq_valid_i & ~sel_mask);
    overrun  = (state_q == StBusy) && sel_valid && !sel_end && (cnt_q == CntW'(MAX_PKT - 1));
  end

`ifdef DAQ_WATCHDOG_EN
  localparam int unsigned WdW = (WD_CYCLES > 1) ? $clog2(WD_CYCLES) : 1;
  logic [WdW-1:0] wd_q;

  assign wd_fire = (state_q != StIdle) && !sel_valid && (wd_q == WdW'(WD_CYCLES - 1));

  // Held at zero while idle so a fresh grant starts a full timeout window.
  always_ff @(posedge clk_i) begin
    if (rst_i || state_q == StIdle || sel_valid) wd_q <= '0;
    else if (!wd_fire)                           wd_q <= wd_q + 1'b1;
  end
`else
  assign wd_fire = 1'b0;
`endif

  always_comb begin
    push      = 1'b0;
    push_end  = sel_end;
    push_data = sel_data;
    if (state_q == StBusy) begin
      if (sel_valid) begin
        push = 1'b1;
        if (cnt_q == CntW'(MAX_PKT - 1)) push_end = 1'b1;
      end else if (wd_fire) begin
        push      = 1'b1;
        push_end  = 1'b1;
        push_data = {DAQ_WD_MARKER, 8'h00, 8'(sel_q)};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      sel_q   <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      err_q   <= 1'b0;
    end else begin
      grant_q <= '0;
      if (err_clear_i)                 err_q <= 1'b0;
      if (stray || overrun || wd_fire) err_q <= 1'b1;
      case (state_q)
        StIdle: begin
          if (pick_found && space_ok) begin
            grant_q <= NREQ'(1) << pick_idx;
            sel_q   <= pick_idx;
            cnt_q   <= '0;
            rr_q    <= (int'(pick_idx) == int'(NREQ) - 1) ? '0 : pick_idx + 1'b1;
            state_q <= StBusy;
          end
        end
        StBusy: begin
          if (sel_valid) begin
            cnt_q <= cnt_q + 1'b1;
            if (sel_end)      state_q <= StIdle;
            else if (overrun) state_q <= StDrain;
          end else if (wd_fire) begin
            state_q <= StIdle;
          end
        end
        StDrain: begin
          if ((sel_valid && sel_end) || wd_fire) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  daq_sync_fifo #(
    .WIDTH (33),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .wdata_i ({push_end, push_data}),
    .pop_i   (out_valid_o & out_ready_i),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fill)
  );

  assign daq_grant_o = grant_q;
  assign err_o       = err_q;
  assign out_valid_o = ~fifo_empty;
  assign out_data_o  = fifo_rdata[31:0];
  assign out_end_o   = fifo_rdata[32];
  assign fill_o      = fill;

endmodule

// File: tb/tb_daq_collector.sv
// Directed bench for daq_collector (DEPTH=8); watchdog expectations follow DAQ_WATCHDOG_EN.
module tb_daq_collector;

`ifdef DAQ_WATCHDOG_EN
  localparam int RESV = 4;
`else
  localparam int RESV = 3;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  daq_req = '0, daq_grant, daq_valid = '0, daq_end = '0;
  logic [63:0] daq_data = '0;
  logic [31:0] out_data;
  logic        out_end, out_valid, out_ready = 1'b0, err, err_clear = 1'b0;
  logic [3:0]  fill;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  daq_collector #(
    .NREQ      (2),
    .DEPTH     (8),
    .MAX_PKT   (3),
    .WD_CYCLES (64)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .daq_req_i   (daq_req),
    .daq_grant_o (daq_grant),
    .daq_data_i  (daq_data),
    .daq_valid_i (daq_valid),
    .daq_end_i   (daq_end),
    .out_data_o  (out_data),
    .out_end_o   (out_end),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .fill_o      (fill),
    .err_o       (err),
    .err_clear_i (err_clear)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic drive_word(input int p, input logic [31:0] d, input logic e);
    daq_valid[p] = 1'b1;
    daq_end[p]   = e;
    daq_data[32*p +: 32] = d;
    tick();
    daq_valid[p] = 1'b0;
    daq_end[p]   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    vectors++;
    if (daq_grant !== 2'b00 || out_valid !== 1'b0 || fill !== 4'd0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: grant=%b valid=%b fill=%0d err=%b, want 00 0 0 0",
               daq_grant, out_valid, fill, err);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_packet();
    logic [31:0] w [3];
    w[0] = 32'h30001500; w[1] = 32'h12345678; w[2] = 32'h00001000;
    out_ready = 1'b1;
    daq_req[0] = 1'b1;
    tick();
    daq_req[0] = 1'b0;
    vectors++;
    if (daq_grant !== 2'b01) begin
      miscompares++;
      $display("FAIL single_grant: got %b want 01", daq_grant);
    end
    for (int k = 0; k < 3; k++) begin
      drive_word(0, w[k], k == 2);
      vectors++;
      if (out_valid !== 1'b1 || out_data !== w[k] || out_end !== (k == 2)) begin
        miscompares++;
        $display("FAIL single_word%0d: got v=%b %h end=%b want 1 %h %b",
                 k, out_valid, out_data, out_end, w[k], k == 2);
      end
    end
    tick();
    vectors++;
    if (fill !== 4'd0 || out_valid !== 1'b0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL single_drained: fill=%0d valid=%b err=%b want 0 0 0", fill, out_valid, err);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    out_ready = 1'b1;
    daq_req = 2'b11;
    tick();
    daq_req[0] = 1'b0;
    vectors++;
    if (daq_grant !== 2'b01) begin
      miscompares++;
      $display("FAIL rr_first: got %b want 01", daq_grant);
    end
    for (int k = 0; k < 3; k++) begin
      drive_word(0, 32'hA000_0000 + k, k == 2);
      vectors++;
      if (daq_grant !== 2'b00) begin
        miscompares++;
        $display("FAIL rr_no_grant_busy%0d: got %b want 00", k, daq_grant);
      end
    end
    tick();
    daq_req[1] = 1'b0;
    vectors++;
    if (daq_grant !== 2'b10) begin
      miscompares++;
      $display("FAIL rr_second: got %b want 10", daq_grant);
    end
    for (int k = 0; k < 3; k++) drive_word(1, 32'hB000_0000 + k, k == 2);
    vectors++;
    if (out_data !== 32'hB000_0002 || out_end !== 1'b1) begin
      miscompares++;
      $display("FAIL rr_p1_last: got %h end=%b want b0000002 1", out_data, out_end);
    end
    daq_req = 2'b11;
    tick();
    daq_req = 2'b00;
    vectors++;
    if (daq_grant !== 2'b01) begin
      miscompares++;
      $display("FAIL rr_wrap: got %b want 01", daq_grant);
    end
    for (int k = 0; k < 3; k++) drive_word(0, 32'hA100_0000 + k, k == 2);
    tick();
  endtask

  task automatic test_backpressure();
    int ngrant;
    do_reset();
    out_ready = 1'b0;
    daq_req[0] = 1'b1;
    tick();
    daq_req[0] = 1'b0;
    for (int k = 0; k < 3; k++) drive_word(0, 32'hC000_0000 + k, k == 2);
    daq_req[1] = 1'b1;
    tick();
    daq_req[1] = 1'b0;
    vectors++;
    if (daq_grant !== 2'b10) begin
      miscompares++;
      $display("FAIL bp_second_grant: got %b want 10", daq_grant);
    end
    for (int k = 0; k < 3; k++) drive_word(1, 32'hD000_0000 + k, k == 2);
    vectors++;
    if (fill !== 4'd6) begin
      miscompares++;
      $display("FAIL bp_fill6: got %0d want 6", fill);
    end
    daq_req[0] = 1'b1;
    ngrant = 0;
    repeat (3) begin
      tick();
      if (daq_grant !== 2'b00) ngrant++;
    end
    vectors++;
    if (ngrant != 0) begin
      miscompares++;
      $display("FAIL bp_hold_no_space: saw %0d grants want 0", ngrant);
    end
    out_ready = 1'b1;
    repeat (RESV - 2) tick();
    out_ready = 1'b0;
    vectors++;
    if (daq_grant !== 2'b00 || fill !== 4'(8 - RESV)) begin
      miscompares++;
      $display("FAIL bp_after_pop: grant=%b fill=%0d want 00 %0d", daq_grant, fill, 8 - RESV);
    end
    tick();
    daq_req[0] = 1'b0;
    vectors++;
    if (daq_grant !== 2'b01) begin
      miscompares++;
      $display("FAIL bp_grant_on_space: got %b want 01", daq_grant);
    end
    for (int k = 0; k < 3; k++) drive_word(0, 32'hE000_0000 + k, k == 2);
    vectors++;
    if (fill !== 4'(11 - RESV) || out_data !== 32'hC000_0000 + 32'(RESV - 2)) begin
      miscompares++;
      $display("FAIL bp_final: fill=%0d head=%h want %0d %h",
               fill, out_data, 11 - RESV, 32'hC000_0000 + 32'(RESV - 2));
    end
    out_ready = 1'b1;
    repeat (8) tick();
    vectors++;
    if (fill !== 4'd0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_drain: fill=%0d valid=%b want 0 0", fill, out_valid);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    out_ready = 1'b1;
    daq_req[0] = 1'b1;
    tick();
    daq_req[0] = 1'b0;
    drive_word(0, 32'h0000_0F00, 1'b0);
    drive_word(0, 32'h0000_0F01, 1'b0);
    drive_word(0, 32'h0000_0F02, 1'b0);
    vectors++;
    if (out_data !== 32'h0000_0F02 || out_end !== 1'b1 || err !== 1'b1) begin
      miscompares++;
      $display("FAIL ovr_forced_end: got %h end=%b err=%b want 00000f02 1 1",
               out_data, out_end, err);
    end
    drive_word(0, 32'h0000_0F03, 1'b0);
    vectors++;
    if (fill !== 4'd0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL ovr_4th_dropped: fill=%0d valid=%b want 0 0", fill, out_valid);
    end
    drive_word(0, 32'h0000_0F04, 1'b1);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    vectors++;
    if (err !== 1'b0 || fill !== 4'd0) begin
      miscompares++;
      $display("FAIL ovr_err_clear: err=%b fill=%0d want 0 0", err, fill);
    end
    err_clear = 1'b1;
    drive_word(1, 32'h5555_5555, 1'b0);
    err_clear = 1'b0;
    vectors++;
    if (err !== 1'b1 || fill !== 4'd0) begin
      miscompares++;
      $display("FAIL ovr_clear_vs_stray: err=%b fill=%0d want 1 0", err, fill);
    end
    daq_req[1] = 1'b1;
    tick();
    daq_req[1] = 1'b0;
    vectors++;
    if (daq_grant !== 2'b10) begin
      miscompares++;
      $display("FAIL ovr_back_to_idle: got %b want 10", daq_grant);
    end
  endtask

  task automatic test_watchdog();
    do_reset();
    out_ready = 1'b0;
    daq_req[1] = 1'b1;
    tick();
    daq_req[1] = 1'b0;
    vectors++;
    if (daq_grant !== 2'b10) begin
      miscompares++;
      $display("FAIL wd_grant: got %b want 10", daq_grant);
    end
    drive_word(1, 32'h0000_ABCD, 1'b0);
`ifdef DAQ_WATCHDOG_EN
    begin
      logic found;
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
        tick();
        if (fill == 4'd2) found = 1'b1;
      end
      vectors++;
      if (!found) begin
        miscompares++;
        $display("FAIL wd_timeout: fill=%0d want 2 within 100 cycles", fill);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      vectors++;
      if (out_data !== 32'hDEAD_0001 || out_end !== 1'b1 || err !== 1'b1) begin
        miscompares++;
        $display("FAIL wd_marker: got %h end=%b err=%b want dead0001 1 1", out_data, out_end, err);
      end
      daq_req[0] = 1'b1;
      tick();
      daq_req[0] = 1'b0;
      vectors++;
      if (daq_grant !== 2'b01) begin
        miscompares++;
        $display("FAIL wd_regrant: got %b want 01", daq_grant);
      end
    end
`else
    begin
      int ngrant;
      repeat (80) tick();
      vectors++;
      if (fill !== 4'd1 || err !== 1'b0) begin
        miscompares++;
        $display("FAIL nowd_hold: fill=%0d err=%b want 1 0", fill, err);
      end
      daq_req[0] = 1'b1;
      ngrant = 0;
      repeat (3) begin
        tick();
        if (daq_grant !== 2'b00) ngrant++;
      end
      daq_req[0] = 1'b0;
      vectors++;
      if (ngrant != 0) begin
        miscompares++;
        $display("FAIL nowd_stuck_busy: saw %0d grants want 0", ngrant);
      end
    end
`endif
  endtask

  task automatic test_reset_midpacket();
    do_reset();
    out_ready = 1'b0;
    daq_req[0] = 1'b1;
    tick();
    daq_req[0] = 1'b0;
    drive_word(0, 32'h7000_0000, 1'b0);
    vectors++;
    if (fill !== 4'd1 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_first_word: fill=%0d valid=%b want 1 1", fill, out_valid);
    end
    do_reset();
    vectors++;
    if (fill !== 4'd0 || out_valid !== 1'b0 || daq_grant !== 2'b00 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_after_reset: fill=%0d valid=%b grant=%b err=%b want 0 0 00 0",
               fill, out_valid, daq_grant, err);
    end
    drive_word(0, 32'h7000_0001, 1'b0);
    drive_word(0, 32'h7000_0002, 1'b1);
    vectors++;
    if (err !== 1'b1 || fill !== 4'd0) begin
      miscompares++;
      $display("FAIL mid_stray: err=%b fill=%0d want 1 0", err, fill);
    end
    daq_req[0] = 1'b1;
    tick();
    daq_req[0] = 1'b0;
    vectors++;
    if (daq_grant !== 2'b01) begin
      miscompares++;
      $display("FAIL mid_regrant: got %b want 01", daq_grant);
    end
    for (int k = 0; k < 3; k++) drive_word(0, 32'h7100_0000 + k, k == 2);
    vectors++;
    if (fill !== 4'd3 || out_data !== 32'h7100_0000 || out_end !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_new_packet: fill=%0d head=%h end=%b want 3 71000000 0",
               fill, out_data, out_end);
    end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_round_robin();
    test_backpressure();
    test_overrun();
    test_watchdog();
    test_reset_midpacket();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
